// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock/strobe generator.
package clk_gen_pkg;

  // Channel output modes
  localparam logic MODE_TOGGLE = 1'b0;  // clk_out flips at each terminal count
  localparam logic MODE_PULSE  = 1'b1;  // clk_out mirrors the one-cycle tick

  // Default counter/divisor width
  localparam int DEFAULT_CNT_W = 32;

  // Output period in system clocks for a given divisor and mode (0 = halted)
  function automatic longint unsigned div_to_period(input longint unsigned div,
                                                    input logic mode);
    if (div == 0)
      return 0;
    else if (mode == MODE_TOGGLE)
      return 2 * div;
    else
      return div;
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One divider channel: free-running counter, registered tick/clk_out, and a
// shadow divisor/mode that is only applied at a period boundary (or whenever
// the channel is stopped), so output periods are never truncated.
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int               CNT_W     = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DIV_INIT  = CNT_W'(1),
  parameter logic             MODE_INIT = MODE_TOGGLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             mode;
  logic [CNT_W-1:0] sh_div;
  logic             sh_mode;

  logic             halted;
  logic             term;
  logic             stop;
  logic             apply;
  logic             mode_chg;
  logic [CNT_W-1:0] nxt_div;
  logic             nxt_mode;

  // Terminal-count, stop and shadow-apply decisions for this cycle
  always_comb begin
    halted   = (div == '0);
    // div==0 is excluded first, so div-1 never wraps around here
    term     = en & ~halted & (cnt == div - CNT_W'(1));
    stop     = restart | ~en | halted;
    // A value accepted this very cycle wins over the stored shadow
    nxt_div  = ld ? ld_div : sh_div;
    nxt_mode = ld ? ld_mode : sh_mode;
    apply    = (ld | pending) & (stop | term);
    mode_chg = apply & (nxt_mode != mode);
  end

  // Counter, active/shadow configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= DIV_INIT;
      mode    <= MODE_INIT;
      sh_div  <= DIV_INIT;
      sh_mode <= MODE_INIT;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (ld) begin
        sh_div  <= ld_div;
        sh_mode <= ld_mode;
      end

      if (apply) begin
        div     <= nxt_div;
        mode    <= nxt_mode;
        pending <= 1'b0;
      end else if (ld) begin
        pending <= 1'b1;
      end

      if (stop) begin
        // restart / disable / halt all beat a terminal count
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (term) begin
        cnt  <= '0;
        tick <= 1'b1;
        if (mode_chg)
          clk_out <= 1'b0;
        else if (mode == MODE_PULSE)
          clk_out <= 1'b1;
        else
          clk_out <= ~clk_out;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (mode == MODE_PULSE)
          clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock/strobe generator: decodes the config port onto one
// channel and slices the per-channel reset divisor/mode vectors.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int                       NUM_CH   = 3,
  parameter int                       CNT_W    = DEFAULT_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_RST  = {32'd1_000_000, 32'd50_000, 32'd50_000_000},
  parameter logic [NUM_CH-1:0]        MODE_RST = '0,
  localparam int                      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              restart,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // Config handshake: a word transfers on any cycle where cfg_valid and
  // cfg_ready are both high. cfg_ready depends only on cfg_ch (and that
  // channel's pending flag), never on cfg_valid. A channel with an unapplied
  // shadow value holds cfg_ready low; channel numbers beyond NUM_CH are
  // always ready and the word is dropped.
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] ld;
  logic [NUM_CH-1:0] pending;

  // Channel select decode
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      hit[i] = (cfg_ch == CH_W'(i));
  end

  // Ready mux and per-channel load strobes
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (hit[i])
        cfg_ready = ~pending[i];
    ld = hit & {NUM_CH{cfg_valid & cfg_ready}};
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_gen_channel #(
      .CNT_W     (CNT_W),
      .DIV_INIT  (DIV_RST[g*CNT_W +: CNT_W]),
      .MODE_INIT (MODE_RST[g])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .restart (restart),
      .ld      (ld[g]),
      .ld_div  (cfg_div),
      .ld_mode (cfg_mode),
      .pending (pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Bench for clk_gen_multi: directed scenarios followed by random traffic,
// all checked against a per-channel behavioural model.
module tb_clk_gen_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] ch_en;
  logic              restart;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  clk_gen_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_RST  ({16'd4, 16'd2, 16'd3}),
    .MODE_RST (3'b000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .ch_en     (ch_en),
    .restart   (restart),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {clk_out, tick} for each clock interval
  logic [2*NUM_CH-1:0] exp_q[$];

  // Behavioural model: each channel counts cycles since its last period
  // boundary ("age"); a boundary occurs when age reaches the divisor.
  int m_div  [NUM_CH];
  int m_age  [NUM_CH];
  int m_sdiv [NUM_CH];
  bit m_mode [NUM_CH];
  bit m_smode[NUM_CH];
  bit m_pend [NUM_CH];
  bit m_out  [NUM_CH];
  bit m_tick [NUM_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_exp();
    logic [2*NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) begin
      v[NUM_CH+i] = m_out[i];
      v[i]        = m_tick[i];
    end
    exp_q.push_back(v);
  endfunction

  function automatic void model_reset();
    m_div = '{3, 2, 4};
    for (int i = 0; i < NUM_CH; i++) begin
      m_sdiv[i]  = m_div[i];
      m_mode[i]  = 1'b0;
      m_smode[i] = 1'b0;
      m_pend[i]  = 1'b0;
      m_out[i]   = 1'b0;
      m_tick[i]  = 1'b0;
      m_age[i]   = 0;
    end
    exp_q.delete();
    push_exp();
  endfunction

  function automatic void model_apply(input int i);
    if (m_smode[i] != m_mode[i])
      m_out[i] = 1'b0;
    m_div[i]  = m_sdiv[i];
    m_mode[i] = m_smode[i];
    m_pend[i] = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs now on the bus
  function automatic void model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_valid && int'(cfg_ch) == i && !m_pend[i]) begin
        m_sdiv[i]  = int'(cfg_div);
        m_smode[i] = cfg_mode;
        m_pend[i]  = 1'b1;
      end
      if (restart || !ch_en[i] || m_div[i] == 0) begin
        m_age[i]  = 0;
        m_tick[i] = 1'b0;
        m_out[i]  = 1'b0;
        if (m_pend[i]) model_apply(i);
      end else begin
        m_age[i]++;
        if (m_age[i] == m_div[i]) begin
          m_age[i]  = 0;
          m_tick[i] = 1'b1;
          m_out[i]  = m_mode[i] ? 1'b1 : !m_out[i];
          if (m_pend[i]) model_apply(i);
        end else begin
          m_tick[i] = 1'b0;
          if (m_mode[i]) m_out[i] = 1'b0;
        end
      end
    end
    push_exp();
  endfunction

  function automatic bit exp_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  // One clock: check outputs mid-cycle, step the model, leave #1 past the edge
  task automatic cycle();
    logic [2*NUM_CH-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("clk_out", 32'(clk_out), 32'(e[2*NUM_CH-1:NUM_CH]));
      chk("tick", 32'(tick), 32'(e[NUM_CH-1:0]));
    end
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;
    restart   = 1'b0;
  endtask

  // Present one config word for n cycles
  task automatic drive_cfg(input int ch, input int div, input bit mode, input int n);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = CNT_W'(div);
    cfg_mode  = mode;
    run(n);
    idle_inputs();
  endtask

  // Run until the model says channel ch has the given age (bounded)
  task automatic wait_age(input int ch, input int age, input string tag);
    int k;
    k = 0;
    while (m_age[ch] != age && k < 64) begin
      cycle();
      k++;
    end
    if (m_age[ch] != age) begin
      errors++;
      $display("FAIL %s timeout got_age=%0d exp_age=%0d", tag, m_age[ch], age);
    end
  endtask

  initial begin
    idle_inputs();
    ch_en = 3'b111;
    rst_n = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    model_reset();

    // Reset divisors 3/2/4 in toggle mode
    run(20);

    // ch0 -> div 3 pulse
    drive_cfg(0, 3, 1'b1, 1);
    run(14);

    // ch1 -> div 10, then div 4 written mid-period
    drive_cfg(1, 10, 1'b0, 1);
    run(25);
    wait_age(1, 2, "wait_ch1_cnt2");
    drive_cfg(1, 4, 1'b0, 1);
    run(30);

    // Second ch1 write while pending, then a ch2 write
    drive_cfg(1, 12, 1'b0, 1);
    drive_cfg(1, 6, 1'b0, 2);
    drive_cfg(2, 5, 1'b0, 1);
    run(30);

    // Out-of-range channel is accepted and dropped
    drive_cfg(3, 7, 1'b1, 2);
    run(4);

    // ch2 halt, then clk/2, then constant-high pulse
    drive_cfg(2, 0, 1'b0, 1);
    run(8);
    drive_cfg(2, 1, 1'b0, 1);
    run(8);
    drive_cfg(2, 1, 1'b1, 1);
    run(8);

    // Restart on ch0's terminal count, with a pending write on ch1
    drive_cfg(0, 5, 1'b0, 1);
    run(12);
    drive_cfg(1, 3, 1'b1, 1);
    wait_age(0, 4, "wait_ch0_last");
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    run(10);

    // Enable drop and re-enable
    ch_en = 3'b010;
    run(4);
    ch_en = 3'b111;
    run(12);

    // Asynchronous reset mid-period
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clk_out", 32'(clk_out), 32'h0);
    chk("async_tick", 32'(tick), 32'h0);
    chk("async_ready", 32'(cfg_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(12);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      cfg_valid = ($urandom_range(3, 0) == 0);
      cfg_ch    = 2'($urandom_range(3, 0));
      cfg_div   = CNT_W'($urandom_range(6, 0));
      cfg_mode  = 1'($urandom_range(1, 0));
      restart   = ($urandom_range(39, 0) == 0);
      for (int i = 0; i < NUM_CH; i++)
        ch_en[i] = ($urandom_range(15, 0) != 0);
      cycle();
    end
    idle_inputs();
    ch_en = 3'b111;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
